// File: rtl/pma_rx_deser.sv
// Serial-to-parallel receive deserializer with K28.5 comma alignment and lock tracking.
module pma_rx_deser #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned COMMA_LOCK = 3,
    parameter int unsigned MIS_THRESH = 4
) (
    input  logic                  Bit_Rate_Clk,
    input  logic                  Rst,
    input  logic                  RX_In_P,
    input  logic                  RX_En,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Data_Valid,
    output logic                  Comma_Det,
    output logic                  Locked
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned CNT_LAST = 9;
    localparam int unsigned EVT_W    = 3;

    localparam logic [DATA_WIDTH-1:0] COMMA_RDN = DATA_WIDTH'(10'h17C);
    localparam logic [DATA_WIDTH-1:0] COMMA_RDP = DATA_WIDTH'(10'h283);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] win_q, win_d, win_next_c;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [EVT_W-1:0]      good_cnt_q, good_cnt_d, good_inc_c;
    logic [EVT_W-1:0]      mis_cnt_q, mis_cnt_d, mis_inc_c;
    logic                  comma_c, boundary_c, emit_c;

    // Next-state, counter and emit decisions for the incoming bit.
    always_comb begin
        win_next_c = {RX_In_P, win_q[DATA_WIDTH-1:1]};
        comma_c    = (win_next_c == COMMA_RDN) || (win_next_c == COMMA_RDP);
        boundary_c = (bit_cnt_q == CNT_W'(CNT_LAST));
        good_inc_c = EVT_W'(good_cnt_q + EVT_W'(1));
        mis_inc_c  = EVT_W'(mis_cnt_q + EVT_W'(1));

        state_d    = state_q;
        win_d      = win_next_c;
        bit_cnt_d  = boundary_c ? CNT_W'(0) : CNT_W'(bit_cnt_q + CNT_W'(1));
        good_cnt_d = good_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        emit_c     = 1'b0;

        if (!RX_En) begin
            state_d    = HUNT;
            win_d      = win_q;
            bit_cnt_d  = CNT_W'(0);
            good_cnt_d = EVT_W'(0);
            mis_cnt_d  = EVT_W'(0);
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (comma_c) begin
                        emit_c     = 1'b1;
                        bit_cnt_d  = CNT_W'(0);
                        good_cnt_d = EVT_W'(1);
                        state_d    = (COMMA_LOCK == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (boundary_c) begin
                        emit_c = 1'b1;
                        if (comma_c) begin
                            good_cnt_d = good_inc_c;
                            if (good_inc_c == EVT_W'(COMMA_LOCK)) begin
                                state_d = LOCKED;
                            end
                        end
                    end else if (comma_c) begin
                        // Comma seen on a new phase: realign to it and restart counting.
                        emit_c     = 1'b1;
                        bit_cnt_d  = CNT_W'(0);
                        good_cnt_d = EVT_W'(1);
                    end
                end
                LOCKED: begin
                    if (boundary_c) begin
                        emit_c = 1'b1;
                        if (comma_c) begin
                            mis_cnt_d = EVT_W'(0);
                        end
                    end else if (comma_c) begin
                        mis_cnt_d = mis_inc_c;
                        if (mis_inc_c == EVT_W'(MIS_THRESH)) begin
                            state_d    = HUNT;
                            bit_cnt_d  = CNT_W'(0);
                            good_cnt_d = EVT_W'(0);
                            mis_cnt_d  = EVT_W'(0);
                        end
                    end
                end
                default: begin
                    state_d    = HUNT;
                    bit_cnt_d  = CNT_W'(0);
                    good_cnt_d = EVT_W'(0);
                    mis_cnt_d  = EVT_W'(0);
                end
            endcase
        end
    end

    // State, window, counters and registered outputs.
    always_ff @(posedge Bit_Rate_Clk) begin
        if (Rst) begin
            state_q    <= HUNT;
            win_q      <= '0;
            bit_cnt_q  <= '0;
            good_cnt_q <= '0;
            mis_cnt_q  <= '0;
            Data_out   <= '0;
            Data_Valid <= 1'b0;
            Comma_Det  <= 1'b0;
            Locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            bit_cnt_q  <= bit_cnt_d;
            good_cnt_q <= good_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
            Data_Valid <= emit_c;
            Comma_Det  <= emit_c & comma_c;
            Locked     <= (state_d == LOCKED);
            if (emit_c) begin
                Data_out <= win_next_c;
            end
        end
    end

endmodule

// File: tb/tb_pma_rx_deser.sv
// Randomized scoreboard bench for pma_rx_deser against a behavioural alignment model.
module tb_pma_rx_deser;

    localparam int unsigned COMMA_LOCK = 3;
    localparam int unsigned MIS_THRESH = 4;

    logic       Bit_Rate_Clk = 1'b0;
    logic       Rst          = 1'b1;
    logic       RX_In_P      = 1'b0;
    logic       RX_En        = 1'b0;
    logic [9:0] Data_out;
    logic       Data_Valid;
    logic       Comma_Det;
    logic       Locked;

    pma_rx_deser #(
        .DATA_WIDTH(10),
        .COMMA_LOCK(COMMA_LOCK),
        .MIS_THRESH(MIS_THRESH)
    ) dut (
        .Bit_Rate_Clk(Bit_Rate_Clk),
        .Rst         (Rst),
        .RX_In_P     (RX_In_P),
        .RX_En       (RX_En),
        .Data_out    (Data_out),
        .Data_Valid  (Data_Valid),
        .Comma_Det   (Comma_Det),
        .Locked      (Locked)
    );

    always #5 Bit_Rate_Clk = ~Bit_Rate_Clk;

    typedef struct {
        int data;
        bit comma;
    } emit_t;

    typedef struct {
        bit locked;
        int dout;
    } status_t;

    emit_t   emit_q[$];
    status_t stat_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the last ten line bits, where the current word phase sits,
    // how far alignment has progressed, and what is currently shown on Data_out.
    int m_bits;
    int m_phase;
    int m_mode;   // 0 searching, 1 confirming, 2 locked
    int m_good;
    int m_mis;
    int m_dout;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_comma(input int w);
        return (w == 'h17C) || (w == 'h283);
    endfunction

    task automatic model_step(input bit r, input bit en, input bit b);
        int    w;
        bit    on_word;
        emit_t e;
        status_t s;
        if (r) begin
            m_bits = 0; m_phase = 0; m_mode = 0; m_good = 0; m_mis = 0; m_dout = 0;
        end else if (!en) begin
            m_phase = 0; m_mode = 0; m_good = 0; m_mis = 0;
        end else begin
            w       = (m_bits / 2) + (int'(b) * 512);
            m_bits  = w;
            on_word = (m_phase == 9);
            m_phase = (m_phase + 1) % 10;
            if (m_mode == 0) begin
                if (is_comma(w)) begin
                    e.data = w; e.comma = 1'b1; emit_q.push_back(e); m_dout = w;
                    m_phase = 0; m_good = 1;
                    m_mode = (COMMA_LOCK == 1) ? 2 : 1;
                end
            end else if (on_word) begin
                e.data = w; e.comma = is_comma(w); emit_q.push_back(e); m_dout = w;
                if (is_comma(w)) begin
                    if (m_mode == 1) begin
                        m_good++;
                        if (m_good >= int'(COMMA_LOCK)) m_mode = 2;
                    end else begin
                        m_mis = 0;
                    end
                end
            end else if (is_comma(w)) begin
                if (m_mode == 1) begin
                    e.data = w; e.comma = 1'b1; emit_q.push_back(e); m_dout = w;
                    m_phase = 0; m_good = 1;
                end else begin
                    m_mis++;
                    if (m_mis >= int'(MIS_THRESH)) begin
                        m_mode = 0; m_phase = 0; m_good = 0; m_mis = 0;
                    end
                end
            end
        end
        s.locked = (m_mode == 2);
        s.dout   = m_dout;
        stat_q.push_back(s);
    endtask

    // Drive one bit period; the model predicts the result of the coming edge.
    task automatic cycle(input bit r, input bit en, input bit b);
        @(negedge Bit_Rate_Clk);
        Rst     = r;
        RX_En   = en;
        RX_In_P = b;
        model_step(r, en, b);
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, w[i]);
    endtask

    task automatic send_bits(input int n, input bit rnd);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic sample_now;
        @(posedge Bit_Rate_Clk);
        #1;
    endtask

    // Monitor: compare every emitted word against the queue, and per-cycle status.
    initial begin
        emit_t   e;
        status_t s;
        forever begin
            @(posedge Bit_Rate_Clk);
            #1;
            if (Data_Valid === 1'b1) begin
                if (emit_q.size() == 0) begin
                    check("unexpected_data_valid", 1, 0);
                end else begin
                    e = emit_q.pop_front();
                    check("data_out", int'(Data_out), e.data);
                    check("comma_det", int'(Comma_Det), int'(e.comma));
                end
            end else if (stat_q.size() != 0 && emit_q.size() != 0) begin
                check("missing_data_valid", int'(Data_Valid), 1);
                void'(emit_q.pop_front());
            end
            if (stat_q.size() != 0) begin
                s = stat_q.pop_front();
                check("locked", int'(Locked), int'(s.locked));
                check("data_out_hold", int'(Data_out), s.dout);
            end
        end
    end

    initial begin
        int sel;
        // Reset state
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        sample_now();
        check("reset_data_out", int'(Data_out), 0);
        check("reset_valid", int'(Data_Valid), 0);
        check("reset_locked", int'(Locked), 0);

        // Random lead-in then a single RD- comma
        send_bits(37, 1'b1);
        send_word(10'h17C);
        sample_now();
        check("first_comma_valid", int'(Data_Valid), 1);
        check("first_comma_flag", int'(Comma_Det), 1);
        check("first_comma_data", int'(Data_out), 'h17C);

        // Two more aligned commas with data between -> lock
        send_word(10'h0AA);
        send_word(10'h17C);
        send_word(10'h0AA);
        send_word(10'h17C);
        sample_now();
        check("lock_after_commas", int'(Locked), 1);

        // Four off-boundary commas drop lock
        send_bits(3, 1'b0);
        for (int i = 0; i < 4; i++) send_word(10'h17C);
        sample_now();
        check("lock_lost", int'(Locked), 0);

        // Relock, then three off-boundary commas followed by an aligned one keep lock
        send_bits(20, 1'b0);
        for (int i = 0; i < 3; i++) send_word(10'h17C);
        send_bits(3, 1'b0);
        for (int i = 0; i < 3; i++) send_word(10'h17C);
        send_bits(7, 1'b0);
        send_word(10'h17C);
        sample_now();
        check("lock_kept", int'(Locked), 1);

        // Reset mid-word while locked
        send_bits(5, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        sample_now();
        check("midlock_reset_locked", int'(Locked), 0);
        check("midlock_reset_data", int'(Data_out), 0);

        // Alternating disparity commas, then RX_En soft clear mid-word
        send_bits(11, 1'b0);
        for (int i = 0; i < 4; i++) send_word((i % 2 == 0) ? 10'h17C : 10'h283);
        send_bits(5, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        sample_now();
        check("soft_clear_locked", int'(Locked), 0);
        check("soft_clear_valid", int'(Data_Valid), 0);

        // Randomized mix
        for (int it = 0; it < 300; it++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 5)       send_word(10'h17C);
            else if (sel < 8)  send_word(10'h283);
            else if (sel < 14) send_word(10'($urandom_range(0, 1023)));
            else if (sel < 17) send_bits(int'($urandom_range(1, 9)), 1'b1);
            else if (sel < 19) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            else               cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        sample_now();
        sample_now();
        check("emit_queue_drained", emit_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
